add512_seq: RTL and testbench
=============================

ADD512_SEQ -- requirements
Module: add512_seq

Interface
REQ-001 SHALL have parameter W, default 512, operand and sum width in bits.
REQ-002 SHALL have parameter SLICE, default 64, adder slice width per cycle; W SHALL be an integer multiple of SLICE; N = W/SLICE (default 8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  addend A.
REQ-008 SHALL have port b  input  W  addend B.
REQ-009 SHALL have port ci  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port sum  output  W  result A+B+ci mod 2^W.
REQ-013 SHALL have port cout  output  1  carry out of bit W-1.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
REQ-016 IDLE: on in_valid&in_ready SHALL register a, b, ci into operand registers, clear slice counter to 0, go to RUN; otherwise stay IDLE.
REQ-017 RUN: each cycle SHALL add slice k of A and B plus the carry register, write the SLICE-bit result into sum bits [k*SLICE +: SLICE], load the slice carry-out into the carry register, increment k.
REQ-018 Carry register SHALL be loaded with ci at accept; slice 0 SHALL use it.
REQ-019 When k==N-1 in RUN, after that slice's write SHALL go to DONE, k wraps to 0, cout = final carry.
REQ-020 Latency: out_valid SHALL rise exactly N cycles after the accept edge (8 cycles default).
REQ-021 DONE: sum and cout SHALL be held stable; on out_ready SHALL go to IDLE next edge; without out_ready SHALL stay DONE indefinitely.
REQ-022 Minimum accept-to-accept period SHALL be N+2 cycles (out_ready tied high).
REQ-023 in_valid while busy SHALL be ignored; operand registers SHALL not change outside the IDLE accept.
REQ-024 out_ready while not out_valid SHALL be ignored.
REQ-025 sum/cout SHALL not be guaranteed meaningful except while out_valid; partial slices SHALL not be exposed as valid.
REQ-026 Result SHALL equal a full W-bit addition for all operand values, including all-ones carry ripple across every slice boundary.

Reset
REQ-027 rst SHALL force state IDLE, k=0, carry=0, sum=0, cout=0, operand registers=0 on the next clk edge.
REQ-028 Reset mid-RUN or in DONE SHALL abort the operation; no out_valid SHALL follow for the aborted operands.
REQ-029 rst SHALL dominate a simultaneous in_valid or out_ready handshake.

Structure
REQ-030 State encodings (IDLE=0, RUN=1, DONE=2) and default W/SLICE SHALL live in a shared add_seq_pkg constants include used by block and bench.
REQ-031 Slice adder SHALL be one sub-module cla_slice (SLICE-bit CLA with Ci, S, Cout), instantiated once and reused every RUN cycle.
REQ-032 Counter width SHALL be clog2(N), minimum 1.

Verification
REQ-033 a=1, b=2, ci=0, out_ready=1 -> out_valid 8 cycles after accept, sum=3, cout=0.
REQ-034 a=all-ones, b=0, ci=1 -> sum=0, cout=1 (carry through all 8 slices).
REQ-035 a=all-ones, b=all-ones, ci=1 -> sum=all-ones, cout=1; hold out_ready=0 for 5 cycles -> sum stable, out_valid held, in_ready=0.
REQ-036 Assert rst at RUN slice 4 -> next cycle state IDLE, in_ready=1, sum=0; no out_valid until a new accept.
REQ-037 in_valid held high with new operands during RUN -> ignored; back-to-back ops with out_ready=1 -> accepts exactly N+2 cycles apart, each result correct.
REQ-038 1000 random a/b/ci with random out_ready stalls -> every result matches reference W-bit sum and carry.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared constants for the sequential sliced adder: state encodings and default widths.
// Used by the adder block and its testbench so both agree on geometry.
// Pure declarations; no logic.
package add_seq_pkg;

  localparam int W_DEF     = 512;
  localparam int SLICE_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice counter width: clog2 of the slice count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// One SLICE-bit adder slice with carry-in and carry-out, built from generate/propagate terms.
// Purely combinational, zero cycles.
// No flow control; the owning sequencer decides when the result is captured.
module cla_slice #(
  parameter int SLICE = 64
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Carry recurrence c[i+1] = g[i] | p[i]&c[i]; carried in a scalar so the
  // tool sees a flat expression tree it can restructure into lookahead form.
  always_comb begin
    logic cc;
    cc = ci;
    s  = '0;
    for (int i = 0; i < SLICE; i++) begin
      s[i] = p[i] ^ cc;
      cc   = g[i] | (p[i] & cc);
    end
    cout = cc;
  end

endmodule

// File: rtl/add512_seq.sv
// Wide adder that sums A+B+ci one SLICE per cycle through a single reused cla_slice.
// Latency: out_valid rises N=W/SLICE cycles after the accept edge.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module add512_seq
  import add_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  // W must be an integer multiple of SLICE; N slices are processed LSB first.
  localparam int N  = W / SLICE;
  localparam int KW = cnt_width(N);

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   k_d;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;

  assign k_d  = k_q + KW'(1);
  assign sl_a = a_q[int'(k_q)*SLICE +: SLICE];
  assign sl_b = b_q[int'(k_q)*SLICE +: SLICE];

  cla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .ci   (carry_q),
    .s    (sl_s),
    .cout (sl_co)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Sequencer: capture operands in IDLE, add one slice per RUN cycle, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            k_q     <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[int'(k_q)*SLICE +: SLICE] <= sl_s;
          carry_q <= sl_co;
          if (k_q == KW'(N - 1)) begin
            k_q     <= '0;
            cout_q  <= sl_co;
            state_q <= ST_DONE;
          end else begin
            k_q <= k_d;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add512_seq.sv
// Directed and random checks of the sequential sliced adder.
module tb_add512_seq;
  import add_seq_pkg::*;

  localparam int W     = W_DEF;
  localparam int SLICE = SLICE_DEF;
  localparam int N     = W / SLICE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  add512_seq #(
    .W     (W),
    .SLICE (SLICE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // One complete operation: accept, count latency, check result, stall, release.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic civ, input int stall, input bit junk);
    logic [W:0] exp_r;
    int t;
    exp_r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, civ};
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    chk({tag, " ready"}, in_ready, 1);
    a = av; b = bv; ci = civ; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 4 * N) begin
      if (junk) begin
        in_valid = 1'b1; a = rnd_w(); b = rnd_w(); ci = ~ci;
      end
      step();
      t++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, t, N);
    chk({tag, " sum"}, sum, exp_r[W-1:0]);
    chk({tag, " cout"}, cout, exp_r[W]);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, " hold sum"}, sum, exp_r[W-1:0]);
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " back idle"}, in_ready, 1);
    chk({tag, " valid drop"}, out_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] av, bv;
    logic [W:0]   exp_q[$];
    int           acc[$];
    int           op, nres;
    bit           seen;

    ones = '1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    step(); step();
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    rst = 1'b0;
    step();

    // Basic, full carry ripple, all-ones with stall.
    do_op("one_plus_two", W'(1), W'(2), 1'b0, 0, 1'b0);
    do_op("ripple", ones, '0, 1'b1, 0, 1'b0);
    do_op("ones_ones", ones, ones, 1'b1, 5, 1'b0);
    do_op("slice_edge", {{(W-SLICE){1'b0}}, {SLICE{1'b1}}}, W'(1), 1'b0, 1, 1'b0);
    do_op("ignore_in", W'(64'h1234_5678), W'(64'hFFFF_FFFF_0000_0001), 1'b1, 0, 1'b1);

    // Reset in RUN at slice 4 aborts the operation.
    a = ones; b = W'(1); ci = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("abort busy before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort in_ready", in_ready, 1);
    chk("abort sum", sum, 0);
    chk("abort busy", busy, 0);
    seen = 1'b0;
    repeat (2 * N) begin step(); if (out_valid) seen = 1'b1; end
    chk("abort no valid", seen, 0);

    // Reset dominates accept in IDLE.
    a = W'(5); b = W'(6); in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst vs accept", busy, 0);

    // Reset dominates release in DONE and clears the result.
    a = W'(7); b = W'(8); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (N) step();
    chk("done reached", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    chk("rst in done valid", out_valid, 0);
    chk("rst in done sum", sum, 0);

    // Back-to-back with out_ready tied high: accepts N+2 cycles apart.
    out_ready = 1'b1; in_valid = 1'b1; op = 0; nres = 0;
    for (int cyc = 0; cyc < 3 * (N + 2) + 4; cyc++) begin
      if (out_valid) begin
        if (nres < exp_q.size()) begin
          chk("b2b sum", sum, exp_q[nres][W-1:0]);
          chk("b2b cout", cout, exp_q[nres][W]);
        end
        nres++;
      end
      if (in_ready && op < 3) begin
        av = rnd_w(); bv = (op == 1) ? ~av : rnd_w();
        a = av; b = bv; ci = op[0];
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, op[0]});
        acc.push_back(cyc);
        op++;
      end else if (op == 3) begin
        in_valid = 1'b0;
      end
      step();
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b results", nres, 3);
    if (acc.size() == 3) begin
      chk("b2b gap1", acc[1] - acc[0], N + 2);
      chk("b2b gap2", acc[2] - acc[1], N + 2);
    end else begin
      chk("b2b accepts", acc.size(), 3);
    end
    step();

    // Random operands with random output stalls.
    for (int i = 0; i < 1000; i++) begin
      av = rnd_w();
      bv = ($urandom_range(0, 7) == 0) ? ~av : rnd_w();
      do_op("random", av, bv, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
